dec_key_schedule: RTL and testbench
===================================

# dec_key_schedule

Converts the AES-256 encryption round-key set produced by `key_expansion` into the decryption round-key set consumed by the inverse cipher datapath.
- Reverses the 15 round keys.
- With the equivalent-inverse feature compiled in, applies InvMixColumns to the 13 inner keys, one key per clock.
- Sits between `key_expansion` and the decryption rounds; it is the decrypt-side consumer of the `round_keys_t` interface.

## Interface
Parameters: none. `round_keys_t` comes from `aes_parameters.svh`: array [0:14] of 128-bit keys, entry 0 = first (cipher-key) round key. Within a key, bits [127:96] = column 0; MSB byte of each column = row 0.
- `clk`  in  1  sole clock; all logic on the rising edge.
- `resetn`  in  1  synchronous, active-high reset (1 = reset).
- `round_keys_i`  in  round_keys_t  encryption round keys from `key_expansion`.
- `round_keys_valid_i`  in  1  round keys valid; a level or a pulse is accepted.
- `dec_round_keys_o`  out  round_keys_t  decryption keys; entry 0 is used first in decryption.
- `dec_round_keys_valid_o`  out  1  one-cycle pulse when the full set is complete.
- `busy_o`  out  1  high while a conversion is in progress.

## Operation
- Start detect: the block registers `round_keys_valid_i` into `valid_q`. A start is a sample with `round_keys_valid_i`=1 and `valid_q`=0, taken while in IDLE.
  - A held-high valid therefore causes exactly one conversion.
  - `valid_q` resets to 0, so a valid that is already high when reset releases starts a conversion.
- FSM states: IDLE, MIX, DONE.
  - IDLE → start:
    - Latch `round_keys_i` into the working copy `enc_q`.
    - Write `dec[0]` = `enc[14]` and `dec[14]` = `enc[0]`.
    - Set counter `idx` = 1.
    - Go to MIX.
  - MIX: each cycle, write `dec[idx]` = InvMixColumns(`enc_q[14-idx]`) and increment `idx`. After writing idx = 13, go to DONE.
    - InvMixColumns uses four parallel column units with GF(2^8) coefficients 0e/0b/0d/09 and reduction polynomial 0x11b.
  - DONE: assert `dec_round_keys_valid_o` for one cycle, then go to IDLE.
- `busy_o` = (state != IDLE).
- A rising valid while busy is ignored; it does not queue and does not restart.
  - `valid_q` keeps tracking the input, so a valid held through completion does not retrigger.
- `round_keys_i` may change after the start cycle; only `enc_q` is used.
- `dec_round_keys_o` entries change only while busy. Between DONE and the next start, all 15 entries hold stable.

## Timing
- Reset (`resetn`=1 at an edge), which also applies mid-conversion:
  - state = IDLE, `idx` = 0, `valid_q` = 0.
  - `busy_o` = 0, `dec_round_keys_valid_o` = 0.
  - `dec_round_keys_o` = all zeros, `enc_q` = all zeros.
  - An aborted conversion produces no valid pulse.
- Latency with the macro defined. Edge E0 is the edge that samples the start.
  - `busy_o` is high from after E0.
  - `dec[idx]` is written at edge E_idx, for idx = 1..13.
  - The DONE state begins after E13, so `dec_round_keys_valid_o` is high for the one cycle between E13 and E14.
  - IDLE resumes at E14; a new start is accepted at E15 at the earliest.
- Throughput: one key set per 15 cycles.
- Simultaneous events: reset wins over start. A start and DONE never coincide, because starts are accepted only in IDLE.

## Configuration
- `DEC_KEY_EQUIV_INV_EN` defined (equivalent inverse cipher):
  - InvMixColumns is applied to entries 1..13.
  - FSM and latency are as above.
- Not defined (straight inverse cipher):
  - `dec[i]` = `enc[14-i]` for all i, with no column units instantiated.
  - IDLE → DONE directly: all 15 entries are written at E0, and the valid pulse occurs between E0 and E1.
  - `busy_o` is high for that one cycle only.

## Test plan
- Reset: hold `resetn`=1 for 10 cycles with valid toggling → `busy_o`=0, `dec_round_keys_valid_o`=0, all outputs 0.
- FIPS-197 key `000102…1e1f` from `key_expansion` (valid held 10 cycles):
  - exactly one valid pulse, 14 cycles after the start edge (1 cycle without the macro);
  - `dec[0]` = 24fc79ccbf0979e9371ac23c6d68de36, `dec[14]` = 000102030405060708090a0b0c0d0e0f;
  - without the macro, `dec[1]` = 4e5a6699a9f24fe07e572baacdf8cdea.
- Synthetic set with the macro, one case per entry 13 value:
  - entry 13 = `8e4da1bc` × 4 → `dec[1]` = `db135345` × 4;
  - entry 13 = `01010101` × 4 → `dec[1]` unchanged;
  - entry 13 = all-zero → `dec[1]` = 0.
- Valid re-asserted (rising) at cycle 5 of a conversion → ignored, single pulse at cycle 14. A fresh rising edge after IDLE → second conversion with new keys.
- Reset asserted at MIX cycle 7 → no valid pulse, outputs zero. With valid still high at reset release → a new conversion starts and completes normally.

Source files
------------

// File: rtl/dec_key_schedule.sv
//----------------------------------------------------------------------------
// Module      : dec_key_schedule
// Description : Converts the AES-256 encryption round-key set into the
//               decryption round-key set. Keys are reversed in order. With
//               DEC_KEY_EQUIV_INV_EN defined, InvMixColumns is applied to
//               the 13 inner keys (one key per clock) for the equivalent
//               inverse cipher. Without it, the whole set is written in a
//               single cycle.
// Ports       : clk                    - sole clock, rising edge
//               resetn                 - synchronous reset, active high
//               round_keys_i           - encryption keys [0:14], entry 0 first
//               round_keys_valid_i     - key set valid (level or pulse)
//               dec_round_keys_o       - decryption keys, entry 0 used first
//               dec_round_keys_valid_o - one-cycle pulse when set complete
//               busy_o                 - high while a conversion runs
// Macro       : DEC_KEY_EQUIV_INV_EN (equivalent-inverse feature)
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module dec_key_schedule (
    input  logic               clk,
    input  logic               resetn,
    input  logic [0:14][127:0] round_keys_i,
    input  logic               round_keys_valid_i,
    output logic [0:14][127:0] dec_round_keys_o,
    output logic               dec_round_keys_valid_o,
    output logic               busy_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MIX  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_valid_q;
    logic               w_start;
    logic [0:14][127:0] r_dec;

    // Edge detect on valid: a held-high valid yields exactly one start.
    assign w_start = round_keys_valid_i & ~r_valid_q & (r_state == S_IDLE);

    assign dec_round_keys_o = r_dec;

    always_ff @(posedge clk) begin
        if (resetn) begin
            r_valid_q <= 1'b0;
            r_state   <= S_IDLE;
        end else begin
            r_valid_q <= round_keys_valid_i;
            r_state   <= w_state_nxt;
        end
    end

`ifdef DEC_KEY_EQUIV_INV_EN

    logic [3:0]         r_idx;
    logic [0:14][127:0] r_enc;
    logic [127:0]       w_mix_in;
    logic [127:0]       w_mix_out;

    function automatic logic [7:0] xt(input logic [7:0] b);
        xt = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] m09(input logic [7:0] b);
        m09 = xt(xt(xt(b))) ^ b;
    endfunction

    function automatic logic [7:0] m0b(input logic [7:0] b);
        m0b = xt(xt(xt(b))) ^ xt(b) ^ b;
    endfunction

    function automatic logic [7:0] m0d(input logic [7:0] b);
        m0d = xt(xt(xt(b))) ^ xt(xt(b)) ^ b;
    endfunction

    function automatic logic [7:0] m0e(input logic [7:0] b);
        m0e = xt(xt(xt(b))) ^ xt(xt(b)) ^ xt(b);
    endfunction

    // One column; byte [31:24] is row 0.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        inv_mix_col = {m0e(a0) ^ m0b(a1) ^ m0d(a2) ^ m09(a3),
                       m09(a0) ^ m0e(a1) ^ m0b(a2) ^ m0d(a3),
                       m0d(a0) ^ m09(a1) ^ m0e(a2) ^ m0b(a3),
                       m0b(a0) ^ m0d(a1) ^ m09(a2) ^ m0e(a3)};
    endfunction

    // dec[idx] is built from enc[14-idx].
    assign w_mix_in = r_enc[4'd14 - r_idx];

    for (genvar c = 0; c < 4; c++) begin : g_col
        assign w_mix_out[127-32*c -: 32] = inv_mix_col(w_mix_in[127-32*c -: 32]);
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            r_idx <= 4'd0;
            r_enc <= '0;
            r_dec <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_enc     <= round_keys_i;
                        r_dec[0]  <= round_keys_i[14];
                        r_dec[14] <= round_keys_i[0];
                        r_idx     <= 4'd1;
                    end
                end
                S_MIX: begin
                    r_dec[r_idx] <= w_mix_out;
                    r_idx        <= r_idx + 4'd1;
                end
                S_DONE:  r_idx <= 4'd0;
                default: r_idx <= 4'd0;
            endcase
        end
    end

    always_comb begin
        w_state_nxt            = r_state;
        busy_o                 = (r_state != S_IDLE);
        dec_round_keys_valid_o = (r_state == S_DONE);
        case (r_state)
            S_IDLE:  if (w_start) w_state_nxt = S_MIX;
            S_MIX:   if (r_idx == 4'd13) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

`else

    logic [0:14][127:0] w_rev;

    for (genvar i = 0; i < 15; i++) begin : g_rev
        assign w_rev[i] = round_keys_i[14-i];
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            r_dec <= '0;
        end else if (w_start) begin
            r_dec <= w_rev;
        end
    end

    // No mixing stage: IDLE goes straight to DONE; MIX is unreachable.
    always_comb begin
        w_state_nxt            = r_state;
        busy_o                 = (r_state != S_IDLE);
        dec_round_keys_valid_o = (r_state == S_DONE);
        case (r_state)
            S_IDLE:  if (w_start) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

`endif

endmodule

`default_nettype wire

// File: tb/tb_dec_key_schedule.sv
//----------------------------------------------------------------------------
// Module      : tb_dec_key_schedule
// Description : Scoreboard bench for dec_key_schedule. Stimulus pushes the
//               expected key set and pulse cycle; a monitor pops and compares
//               on every dec_round_keys_valid_o pulse.
// Macro       : DEC_KEY_EQUIV_INV_EN selects expected latency and mixing.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module tb_dec_key_schedule;

    typedef logic [0:14][127:0] keys_t;
    typedef struct {
        keys_t keys;
        int    cyc;
    } exp_t;

`ifdef DEC_KEY_EQUIV_INV_EN
    localparam int LAT = 13;
`else
    localparam int LAT = 0;
`endif

    logic  clk;
    logic  resetn;
    keys_t round_keys_i;
    logic  round_keys_valid_i;
    keys_t dec_round_keys_o;
    logic  dec_round_keys_valid_o;
    logic  busy_o;

    int    cyc;
    int    checks;
    int    errors;
    exp_t  sb[$];

    dec_key_schedule u_dut (
        .clk                    (clk),
        .resetn                 (resetn),
        .round_keys_i           (round_keys_i),
        .round_keys_valid_i     (round_keys_valid_i),
        .dec_round_keys_o       (dec_round_keys_o),
        .dec_round_keys_valid_o (dec_round_keys_valid_o),
        .busy_o                 (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Shift-and-add GF(2^8) multiply, polynomial 0x11b.
    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] coef(input int k);
        case (k)
            0:       return 8'h0e;
            1:       return 8'h0b;
            2:       return 8'h0d;
            default: return 8'h09;
        endcase
    endfunction

    function automatic logic [127:0] inv_mix_model(input logic [127:0] k);
        logic [127:0] o;
        logic [7:0]   acc;
        o = '0;
        for (int col = 0; col < 4; col++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int c = 0; c < 4; c++)
                    acc = acc ^ gm(coef((c - r + 4) % 4), k[127-32*col-8*c -: 8]);
                o[127-32*col-8*r -: 8] = acc;
            end
        end
        return o;
    endfunction

    function automatic keys_t model(input keys_t k);
        keys_t d;
        for (int i = 0; i < 15; i++) begin
            d[i] = k[14-i];
            if (LAT != 0 && i >= 1 && i <= 13) d[i] = inv_mix_model(k[14-i]);
        end
        return d;
    endfunction

    // Monitor: every valid pulse must match the oldest expected entry.
    always @(negedge clk) begin
        if (dec_round_keys_valid_o === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse actual=1 required=0 at cycle %0d", cyc);
            end else begin
                exp_t x;
                x = sb.pop_front();
                chk("pulse_cycle", 128'(cyc), 128'(x.cyc));
                for (int e = 0; e < 15; e++)
                    chk($sformatf("sb_dec%0d", e), dec_round_keys_o[e], x.keys[e]);
            end
        end
    end

    // Start a conversion: valid held for 'hold' sampling edges; keys are
    // scrambled after the start edge since only the latched copy may matter.
    task automatic start_conv(input keys_t k, input int hold);
        exp_t x;
        @(negedge clk);
        round_keys_i       = k;
        round_keys_valid_i = 1'b1;
        x.keys = model(k);
        x.cyc  = cyc + 1 + LAT;
        sb.push_back(x);
        @(negedge clk);
        round_keys_i = ~k;
        repeat (hold - 1) @(negedge clk);
        round_keys_valid_i = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((sb.size() != 0 || busy_o !== 1'b0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_timeout"}, 128'(n >= 200), 128'(0));
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_reset_state(input string name);
        chk({name, "_busy"}, busy_o, 1'b0);
        chk({name, "_valid"}, dec_round_keys_valid_o, 1'b0);
        for (int e = 0; e < 15; e++)
            chk($sformatf("%s_dec%0d", name, e), dec_round_keys_o[e], 128'h0);
    endtask

    keys_t fips, syn, ka, kb;
    logic [127:0] e13 [3];
    logic [127:0] d1  [3];

    initial begin
        checks = 0;
        errors = 0;
        resetn = 1'b1;
        round_keys_valid_i = 1'b0;
        round_keys_i = '0;

        fips[0]  = 128'h000102030405060708090a0b0c0d0e0f;
        fips[1]  = 128'h101112131415161718191a1b1c1d1e1f;
        fips[2]  = 128'ha573c29fa176c498a97fce93a572c09c;
        fips[3]  = 128'h1651a8cd0244beda1a5da4c10640bade;
        fips[4]  = 128'hae87dff00ff11b68a68ed5fb03fc1567;
        fips[5]  = 128'h6de1f1486fa54f9275f8eb5373b8518d;
        fips[6]  = 128'hc656827fc9a799176f294cec6cd5598b;
        fips[7]  = 128'h3de23a75524775e727bf9eb45407cf39;
        fips[8]  = 128'h0bdc905fc27b0948ad5245a4c1871c2f;
        fips[9]  = 128'h45f5a66017b2d387300d4d33640a820a;
        fips[10] = 128'h7ccff71cbeb4fe5413e6bbf0d261a7df;
        fips[11] = 128'hf01afafee7a82979d7a5644ab3afe640;
        fips[12] = 128'h2541fe719bf500258813bbd55a721c0a;
        fips[13] = 128'h4e5a6699a9f24fe07e572baacdf8cdea;
        fips[14] = 128'h24fc79ccbf0979e9371ac23c6d68de36;

        // Reset held with valid toggling.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk_reset_state("reset");
            round_keys_valid_i = ~round_keys_valid_i;
        end
        @(negedge clk);
        round_keys_valid_i = 1'b0;
        @(negedge clk);
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_busy", busy_o, 1'b0);

        // FIPS-197 AES-256 key schedule, valid held for 10 cycles.
        start_conv(fips, 10);
        wait_done("fips");
        chk("fips_dec0", dec_round_keys_o[0], 128'h24fc79ccbf0979e9371ac23c6d68de36);
        chk("fips_dec14", dec_round_keys_o[14], 128'h000102030405060708090a0b0c0d0e0f);
`ifndef DEC_KEY_EQUIV_INV_EN
        chk("fips_dec1", dec_round_keys_o[1], 128'h4e5a6699a9f24fe07e572baacdf8cdea);
`endif
        repeat (5) @(negedge clk);
        chk("hold_dec0", dec_round_keys_o[0], 128'h24fc79ccbf0979e9371ac23c6d68de36);

        // Synthetic sets: entry 13 selects the InvMixColumns case.
        e13[0] = {4{32'h8e4da1bc}};
        e13[1] = {4{32'h01010101}};
        e13[2] = 128'h0;
`ifdef DEC_KEY_EQUIV_INV_EN
        d1[0] = {4{32'hdb135345}};
        d1[1] = {4{32'h01010101}};
        d1[2] = 128'h0;
`else
        d1[0] = e13[0];
        d1[1] = e13[1];
        d1[2] = e13[2];
`endif
        for (int j = 0; j < 3; j++) begin
            for (int i = 0; i < 15; i++) syn[i] = {16{8'(i * 17 + j + 3)}};
            syn[13] = e13[j];
            start_conv(syn, 1);
            wait_done("syn");
            chk($sformatf("syn%0d_dec1", j), dec_round_keys_o[1], d1[j]);
        end

        // Valid re-raised at cycle 5 of a conversion.
        for (int i = 0; i < 15; i++) ka[i] = {4{32'(i) * 32'h01020304 + 32'h0badcafe}};
        start_conv(ka, 1);
        repeat (4) @(negedge clk);
        round_keys_valid_i = 1'b1;
        if (LAT == 0) begin
            // Already idle again: this rise is a genuine new start.
            exp_t x;
            x.keys = model(round_keys_i);
            x.cyc  = cyc + 1 + LAT;
            sb.push_back(x);
        end
        repeat (3) @(negedge clk);
        round_keys_valid_i = 1'b0;
        wait_done("reassert");

        // Fresh rising edge after idle with new keys.
        for (int i = 0; i < 15; i++) kb[i] = {4{32'(i) * 32'h11111111 ^ 32'hdeadbeef}};
        start_conv(kb, 1);
        wait_done("second");
        chk("second_dec14", dec_round_keys_o[14], kb[0]);

        // Reset mid-conversion with valid still high at release.
        @(negedge clk);
        round_keys_i       = ka;
        round_keys_valid_i = 1'b1;
        begin
            exp_t x;
            x.keys = model(ka);
            x.cyc  = cyc + 1 + LAT;
            sb.push_back(x);
        end
        repeat (8) @(negedge clk);
        resetn = 1'b1;
        sb.delete();
        @(negedge clk);
        chk_reset_state("midreset");
        @(negedge clk);
        resetn = 1'b0;
        begin
            exp_t x;
            x.keys = model(ka);
            x.cyc  = cyc + 1 + LAT;
            sb.push_back(x);
        end
        repeat (3) @(negedge clk);
        round_keys_valid_i = 1'b0;
        wait_done("restart");
        chk("restart_dec0", dec_round_keys_o[0], ka[14]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
